litedram_axi_gate: RTL
======================

// Module: litedram_axi_gate
// PURPOSE
//  Sits between the SoC AXI interconnect and the LiteDRAM core user AXI port, in the user_clk domain.
//  Synchronises the raw init status, holds off AXI traffic until calibration succeeds and limits outstanding bursts.
//  On calibration failure or init timeout it answers all AXI traffic with SLVERR, so the CPU never hangs on DRAM.
//  Parametrised successor of the fixed-width LiteDRAM wrapper glue.
// PARAMETERS
//  ID_WIDTH         1      AXI ID width (>=1)
//  ADDR_WIDTH       27     AXI address width
//  DATA_WIDTH       64     AXI data width; strobe width is DATA_WIDTH/8
//  SYNC_STAGES      2      flops in each init-status synchroniser (>=2)
//  MAX_OUTSTANDING  4      max in-flight bursts per direction (>=1)
//  INIT_TIMEOUT     0      cycles to wait for init before forcing error; 0 disables the timeout
// PORTS
//  user_clk          in   1    sole clock
//  user_rst          in   1    reset; asynchronous, active-high
//  i_init_done_raw   in   1    LiteDRAM init_done, unsynchronised
//  i_init_error_raw  in   1    LiteDRAM init_error, unsynchronised
//  o_init_done       out  1    high when state==READY
//  o_init_error      out  1    high when state==ERROR
//  o_timeout         out  1    sticky; ERROR was entered through the timeout
//  i_aw*/o_awready   s    -    upstream AW: id, addr, len[7:0], size[3:0], burst[1:0], valid
//  i_w*/o_wready     s    -    upstream W: data, strb, last, valid
//  o_b*/i_bready     s    -    upstream B: id, resp[1:0], valid
//  i_ar*/o_arready   s    -    upstream AR: same fields as AW
//  o_r*/i_rready     s    -    upstream R: id, data, resp[1:0], last, valid
//  o_m_*/i_m_*       m    -    the same five channels toward the LiteDRAM user port, mirrored direction
// BEHAVIOUR
//  Reset: state=WAIT_INIT; synchronisers, counters, timer and responder all cleared.
//   All upstream ready/valid outputs, all o_m_*valid, o_init_done, o_init_error and o_timeout are 0.
//  Sync: each raw status bit passes through SYNC_STAGES flops, giving sdone and serror.
//  FSM (state register):
//   WAIT_INIT->ERROR if serror, or if INIT_TIMEOUT!=0 and timer==INIT_TIMEOUT-1 (also sets o_timeout). serror has priority.
//   WAIT_INIT->READY if sdone && !serror.
//   READY and ERROR are sticky until reset.
//  Timer: counts cycles in WAIT_INIT; width is clog2(INIT_TIMEOUT+1).
//  Latency: raw edge -> state change and output at clock edge SYNC_STAGES+1.
//  WAIT_INIT: all upstream readys and all o_m_*valid are 0; nothing is accepted.
//  READY, pass-through: combinational, no added latency, except for outstanding gating.
//   wcnt +1 on m_AW handshake, -1 on m_B handshake.
//   rcnt +1 on m_AR handshake, -1 on m_R handshake with rlast.
//   A simultaneous +1 and -1 leaves the count unchanged.
//   When wcnt==MAX_OUTSTANDING: o_awready=0 and o_m_awvalid=0. AR is gated the same way by rcnt.
//   W, B and R are never gated.
//  ERROR responder (o_m_*valid held 0, downstream readys ignored):
//   Write FSM W_IDLE->W_DATA->W_RESP->W_IDLE.
//    W_IDLE: o_awready=1; AW handshake captures awid.
//    W_DATA: o_wready=1; leave on wvalid&&wlast. Beats are discarded and the beat count is not checked.
//    W_RESP: o_bvalid=1, o_bresp=2'b10, o_bid=captured id; return to W_IDLE on bready.
//   Read FSM R_IDLE->R_DATA->R_IDLE.
//    R_IDLE: o_arready=1; captures arid and arlen, beat counter=0.
//    R_DATA: o_rvalid=1, o_rdata=0, o_rresp=2'b10, o_rid=captured id, o_rlast=(beat==arlen).
//    Beat counter increments on rready; return to R_IDLE on rready&&rlast.
//   Read and write FSMs are independent; one burst per direction is in flight.
//  Reset mid-operation: everything clears immediately (asynchronous); any in-flight burst is abandoned.
//   The LiteDRAM core shares user_rst.
// TESTING
//  1. SYNC_STAGES=2; raw done rises at edge 0 while AW is valid.
//     -> o_init_done=1 after edge 3; awready=0 and m_awvalid=0 before that.
//  2. READY, MAX_OUTSTANDING=2; three ARs issued with no R.
//     -> third AR stalls. One R with rlast -> third AR forwarded the next cycle.
//  3. READY, wcnt=1; AW and B handshakes in the same cycle -> wcnt stays 1.
//  4. raw error. Write awid=3, awlen=3, 4 W beats -> one B with bid=3, bresp=2'b10.
//     Read arid=5, arlen=7 -> 8 R beats, rdata=0, rresp=2'b10, rlast on beat 8 only.
//  5. INIT_TIMEOUT=100, raw status held low -> o_init_error=1 and o_timeout=1 from edge 100; DRAM port stays idle.
//  6. user_rst asserted mid error-mode read at beat 3 -> o_rvalid=0 immediately.
//     After release: WAIT_INIT, all counters 0.

Source files
------------

// File: rtl/litedram_axi_gate.sv
// AXI gate in front of the LiteDRAM user port: holds traffic until calibration completes,
// limits in-flight bursts, and answers everything with SLVERR once init has failed.
module litedram_axi_gate #(
   parameter int ID_WIDTH        = 1,
   parameter int ADDR_WIDTH      = 27,
   parameter int DATA_WIDTH      = 64,
   parameter int SYNC_STAGES     = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int INIT_TIMEOUT    = 0
) (
   input  logic                    user_clk,
   input  logic                    user_rst,
   input  logic                    i_init_done_raw,
   input  logic                    i_init_error_raw,
   output logic                    o_init_done,
   output logic                    o_init_error,
   output logic                    o_timeout,
   // upstream AW
   input  logic [ID_WIDTH-1:0]     i_awid,
   input  logic [ADDR_WIDTH-1:0]   i_awaddr,
   input  logic [7:0]              i_awlen,
   input  logic [3:0]              i_awsize,
   input  logic [1:0]              i_awburst,
   input  logic                    i_awvalid,
   output logic                    o_awready,
   // upstream W
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   input  logic                    i_wlast,
   input  logic                    i_wvalid,
   output logic                    o_wready,
   // upstream B
   output logic [ID_WIDTH-1:0]     o_bid,
   output logic [1:0]              o_bresp,
   output logic                    o_bvalid,
   input  logic                    i_bready,
   // upstream AR
   input  logic [ID_WIDTH-1:0]     i_arid,
   input  logic [ADDR_WIDTH-1:0]   i_araddr,
   input  logic [7:0]              i_arlen,
   input  logic [3:0]              i_arsize,
   input  logic [1:0]              i_arburst,
   input  logic                    i_arvalid,
   output logic                    o_arready,
   // upstream R
   output logic [ID_WIDTH-1:0]     o_rid,
   output logic [DATA_WIDTH-1:0]   o_rdata,
   output logic [1:0]              o_rresp,
   output logic                    o_rlast,
   output logic                    o_rvalid,
   input  logic                    i_rready,
   // downstream AW
   output logic [ID_WIDTH-1:0]     o_m_awid,
   output logic [ADDR_WIDTH-1:0]   o_m_awaddr,
   output logic [7:0]              o_m_awlen,
   output logic [3:0]              o_m_awsize,
   output logic [1:0]              o_m_awburst,
   output logic                    o_m_awvalid,
   input  logic                    i_m_awready,
   // downstream W
   output logic [DATA_WIDTH-1:0]   o_m_wdata,
   output logic [DATA_WIDTH/8-1:0] o_m_wstrb,
   output logic                    o_m_wlast,
   output logic                    o_m_wvalid,
   input  logic                    i_m_wready,
   // downstream B
   input  logic [ID_WIDTH-1:0]     i_m_bid,
   input  logic [1:0]              i_m_bresp,
   input  logic                    i_m_bvalid,
   output logic                    o_m_bready,
   // downstream AR
   output logic [ID_WIDTH-1:0]     o_m_arid,
   output logic [ADDR_WIDTH-1:0]   o_m_araddr,
   output logic [7:0]              o_m_arlen,
   output logic [3:0]              o_m_arsize,
   output logic [1:0]              o_m_arburst,
   output logic                    o_m_arvalid,
   input  logic                    i_m_arready,
   // downstream R
   input  logic [ID_WIDTH-1:0]     i_m_rid,
   input  logic [DATA_WIDTH-1:0]   i_m_rdata,
   input  logic [1:0]              i_m_rresp,
   input  logic                    i_m_rlast,
   input  logic                    i_m_rvalid,
   output logic                    o_m_rready
);

   localparam int TW = (INIT_TIMEOUT > 0) ? $clog2(INIT_TIMEOUT + 1) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(INIT_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_MAX      = CW'(MAX_OUTSTANDING);
   localparam logic [1:0]    SLVERR       = 2'b10;

   typedef enum logic [1:0] {WAIT_INIT, READY, ERROR} state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic       {R_IDLE, R_DATA} rstate_t;

   state_t                  state;
   wstate_t                 wstate;
   rstate_t                 rstate;
   logic [SYNC_STAGES-1:0]  done_sync;
   logic [SYNC_STAGES-1:0]  error_sync;
   logic [TW-1:0]           timer;
   logic [CW-1:0]           wcnt;
   logic [CW-1:0]           rcnt;
   logic [ID_WIDTH-1:0]     err_bid;
   logic [ID_WIDTH-1:0]     err_rid;
   logic [7:0]              err_arlen;
   logic [7:0]              beat;

   logic sdone, serror, ready, err, wfull, rfull;
   logic aw_inc, b_dec, ar_inc, r_dec;

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         done_sync  <= '0;
         error_sync <= '0;
      end else begin
         done_sync  <= {done_sync[SYNC_STAGES-2:0], i_init_done_raw};
         error_sync <= {error_sync[SYNC_STAGES-2:0], i_init_error_raw};
      end
   end

   assign sdone  = done_sync[SYNC_STAGES-1];
   assign serror = error_sync[SYNC_STAGES-1];

   // Status outputs are registered alongside the state so they change on the same edge.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         state        <= WAIT_INIT;
         timer        <= '0;
         o_init_done  <= 1'b0;
         o_init_error <= 1'b0;
         o_timeout    <= 1'b0;
      end else if (state == WAIT_INIT) begin
         if (serror) begin
            state        <= ERROR;
            o_init_error <= 1'b1;
         end else if (INIT_TIMEOUT != 0 && timer == TIMEOUT_LAST) begin
            state        <= ERROR;
            o_init_error <= 1'b1;
            o_timeout    <= 1'b1;
         end else if (sdone) begin
            state       <= READY;
            o_init_done <= 1'b1;
         end else begin
            timer <= timer + TW'(1);
         end
      end
   end

   assign ready = (state == READY);
   assign err   = (state == ERROR);
   assign wfull = (wcnt == CNT_MAX);
   assign rfull = (rcnt == CNT_MAX);

   assign o_m_awid    = i_awid;
   assign o_m_awaddr  = i_awaddr;
   assign o_m_awlen   = i_awlen;
   assign o_m_awsize  = i_awsize;
   assign o_m_awburst = i_awburst;
   assign o_m_awvalid = ready && i_awvalid && !wfull;
   assign o_awready   = (ready && i_m_awready && !wfull) || (err && wstate == W_IDLE);

   assign o_m_wdata   = i_wdata;
   assign o_m_wstrb   = i_wstrb;
   assign o_m_wlast   = i_wlast;
   assign o_m_wvalid  = ready && i_wvalid;
   assign o_wready    = (ready && i_m_wready) || (err && wstate == W_DATA);

   assign o_m_bready  = ready && i_bready;
   assign o_bvalid    = (ready && i_m_bvalid) || (err && wstate == W_RESP);
   assign o_bid       = err ? err_bid : i_m_bid;
   assign o_bresp     = err ? SLVERR : i_m_bresp;

   assign o_m_arid    = i_arid;
   assign o_m_araddr  = i_araddr;
   assign o_m_arlen   = i_arlen;
   assign o_m_arsize  = i_arsize;
   assign o_m_arburst = i_arburst;
   assign o_m_arvalid = ready && i_arvalid && !rfull;
   assign o_arready   = (ready && i_m_arready && !rfull) || (err && rstate == R_IDLE);

   assign o_m_rready  = ready && i_rready;
   assign o_rvalid    = (ready && i_m_rvalid) || (err && rstate == R_DATA);
   assign o_rid       = err ? err_rid : i_m_rid;
   assign o_rdata     = err ? '0 : i_m_rdata;
   assign o_rresp     = err ? SLVERR : i_m_rresp;
   assign o_rlast     = err ? (beat == err_arlen) : i_m_rlast;

   assign aw_inc = o_m_awvalid && i_m_awready;
   assign b_dec  = i_m_bvalid && o_m_bready;
   assign ar_inc = o_m_arvalid && i_m_arready;
   assign r_dec  = i_m_rvalid && o_m_rready && i_m_rlast;

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         wcnt <= '0;
         rcnt <= '0;
      end else begin
         if (aw_inc && !b_dec)
            wcnt <= wcnt + CW'(1);
         else if (!aw_inc && b_dec && wcnt != '0)
            wcnt <= wcnt - CW'(1);
         if (ar_inc && !r_dec)
            rcnt <= rcnt + CW'(1);
         else if (!ar_inc && r_dec && rcnt != '0)
            rcnt <= rcnt - CW'(1);
      end
   end

   // Error responder: W beats are swallowed without counting against awlen.
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         wstate  <= W_IDLE;
         err_bid <= '0;
      end else begin
         case (wstate)
            W_IDLE: if (err && i_awvalid) begin
               err_bid <= i_awid;
               wstate  <= W_DATA;
            end
            W_DATA: if (i_wvalid && i_wlast) wstate <= W_RESP;
            W_RESP: if (i_bready) wstate <= W_IDLE;
            default: wstate <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         rstate    <= R_IDLE;
         err_rid   <= '0;
         err_arlen <= '0;
         beat      <= '0;
      end else begin
         case (rstate)
            R_IDLE: if (err && i_arvalid) begin
               err_rid   <= i_arid;
               err_arlen <= i_arlen;
               beat      <= '0;
               rstate    <= R_DATA;
            end
            R_DATA: if (i_rready) begin
               beat <= beat + 8'd1;
               if (beat == err_arlen) rstate <= R_IDLE;
            end
            default: rstate <= R_IDLE;
         endcase
      end
   end

endmodule
